// File: rtl/clk_div_monitor.sv
// Measures each clk_div period in clk_in cycles, declares lock after a run of good periods and holds a sticky fault.
// Optional duty check: define CLK_DIV_MONITOR_DUTY_CHECK_EN to also require a high time of EXPECTED_RATIO/2 +/- TOLERANCE.
module clk_div_monitor #(
    parameter int EXPECTED_RATIO = 4,
    parameter int TOLERANCE      = 0,
    parameter int LOCK_COUNT     = 4,
    localparam int CNT_W         = $clog2(2 * EXPECTED_RATIO + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clk_div,
    input  logic             clear,
    output logic             edge_strobe,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_e;

    localparam int GC_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * EXPECTED_RATIO);

    logic             sync1_q, sync2_q, prev_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_period;
    logic             period_good;
    logic             timeout;

    state_e           state_q;
    logic [GC_W-1:0]  gc_q;
    logic             edge_strobe_q, period_valid_q, locked_q, fault_q;
    logic [CNT_W-1:0] period_q;

    function automatic logic within_tol(input int meas, input int nominal);
        int dev;
        dev = (meas >= nominal) ? meas - nominal : nominal - meas;
        return dev <= TOLERANCE;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= clk_div;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || rise) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // The rise cycle itself belongs to the completed period, hence the +1.
    assign meas_period = cnt_q + CNT_W'(1);
    assign timeout     = (cnt_q == CNT_MAX) && !rise;

`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
    logic [CNT_W-1:0] hi_q, hi_d;

    always_comb begin
        hi_d = hi_q;
        if (clear || rise) begin
            hi_d = '0;
        end else if (sync2_q && (hi_q != CNT_MAX)) begin
            hi_d = hi_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) hi_q <= '0;
        else        hi_q <= hi_d;
    end

    always_comb begin
        period_good = within_tol(int'(meas_period), EXPECTED_RATIO);
        period_good = period_good && within_tol(int'(hi_q) + 1, EXPECTED_RATIO / 2);
    end
`else
    always_comb begin
        period_good = within_tol(int'(meas_period), EXPECTED_RATIO);
    end
`endif

    // A rise coinciding with clear is dropped entirely, including its strobe.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            gc_q           <= '0;
            edge_strobe_q  <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            edge_strobe_q  <= rise && !clear;
            period_valid_q <= 1'b0;
            if (clear) begin
                state_q  <= IDLE;
                gc_q     <= '0;
                locked_q <= 1'b0;
                fault_q  <= 1'b0;
            end else begin
                if (rise && (state_q != IDLE)) begin
                    period_q       <= meas_period;
                    period_valid_q <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= MEASURE;
                            gc_q    <= '0;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            if (!period_good) begin
                                gc_q <= '0;
                            end else if (gc_q == GC_W'(LOCK_COUNT - 1)) begin
                                state_q  <= LOCKED;
                                gc_q     <= '0;
                                locked_q <= 1'b1;
                            end else begin
                                gc_q <= gc_q + GC_W'(1);
                            end
                        end else if (timeout) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if ((rise && !period_good) || timeout) begin
                            state_q  <= FAULT;
                            locked_q <= 1'b0;
                            fault_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= FAULT;
                    end
                endcase
            end
        end
    end

    assign edge_strobe  = edge_strobe_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign fault        = fault_q;
    assign state_dbg    = state_q;

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Fast-domain monitor for a divided clock. It samples a `clk_div` signal produced by the team's clock divider and synchronizes it into `clk_in`. It measures each rising-to-rising period in `clk_in` cycles, declares lock after a run of in-tolerance periods, and raises a sticky fault on a bad period or a stalled clock. It sits beside the divider and gates downstream logic that relies on the divided clock.

## Interface
Parameters:
- `EXPECTED_RATIO`, 4: nominal `clk_in` cycles per `clk_div` period; even, ≥2.
- `TOLERANCE`, 0: allowed absolute deviation of a measured period, in cycles.
- `LOCK_COUNT`, 4: consecutive good periods required to lock; ≥1.

Ports:
- `clk_in` input 1: monitor clock.
- `rst_n` input 1: reset, asynchronous, active-low; clock `clk_in`.
- `clk_div` input 1: divided clock under test; treated as asynchronous.
- `clear` input 1: synchronous; clears fault and restarts acquisition.
- `edge_strobe` output 1: one-cycle pulse per detected `clk_div` rising edge.
- `period` output CNT_W: last measured period. CNT_W = $clog2(2*EXPECTED_RATIO+1).
- `period_valid` output 1: one-cycle pulse when `period` updates.
- `locked` output 1: high in LOCKED state only.
- `fault` output 1: high in FAULT state only.

## Operation
- Input path: 2-flop synchronizer, then a previous-sample flop. `rise = sync2 & ~prev`.
- Cycle counter `cnt`, CNT_W bits:
  - Cleared to 0 on `rise`.
  - Otherwise increments each cycle.
  - Saturates at 2*EXPECTED_RATIO.
- On `rise`, measured period = `cnt`+1. The period is good iff |period − EXPECTED_RATIO| ≤ TOLERANCE, computed unsigned without wrap.
- FSM states:
  - IDLE: wait indefinitely for the first `rise`, then go to MEASURE with good-count=0. No period is reported for this first edge.
  - MEASURE: on each `rise`, report the period.
    - Good period: good-count+1. Go to LOCKED when good-count reaches LOCK_COUNT.
    - Bad period: good-count=0, stay in MEASURE.
    - Timeout: `cnt` reaching 2*EXPECTED_RATIO without a `rise` → FAULT.
  - LOCKED: report each period. A bad period or a timeout → FAULT.
  - FAULT: sticky. `rise` still updates `period`/`period_valid`/`edge_strobe`. Only `clear` exits, to IDLE.
- `clear` in any state → IDLE, good-count=0, `cnt`=0. A `rise` in the same cycle is ignored.
- `rst_n` low at any time, including mid-lock, asynchronously returns the FSM to IDLE with every flop zeroed.

## Timing
- Reset values: `edge_strobe`=0, `period`=0, `period_valid`=0, `locked`=0, `fault`=0, synchronizer flops=0, state=IDLE.
- `clk_div` rising at clk_in edge N (launched from `clk_in`) → `edge_strobe` high for one cycle after edge N+3.
- `period_valid` and the new `period` occur in the same cycle as `edge_strobe`. In IDLE, `period_valid` stays 0.
- `locked`, `fault`, and the state update in that same cycle; all outputs are registered.
- Timeout fires in the cycle `cnt` reaches 2*EXPECTED_RATIO, i.e. 2*EXPECTED_RATIO cycles after the last `edge_strobe`. `fault` rises the following cycle.
- `clear` asserted at edge M → `fault`=0, `locked`=0 after edge M.

## Configuration
- `CLK_DIV_MONITOR_DUTY_CHECK_EN` defined:
  - An extra high-time counter is cleared on `rise` and counts cycles while `sync2`=1.
  - On each `rise`, the period is good only if the period check passes and the high time of the completed period is within EXPECTED_RATIO/2 ± TOLERANCE.
  - A failing duty check is handled exactly like a bad period.
- Not defined: high time is not tracked. Only the period check applies, and no duty logic is synthesized.

## Test plan
All scenarios use EXPECTED_RATIO=4, TOLERANCE=0, LOCK_COUNT=4.
- Clean divide-by-4 after reset → IDLE→MEASURE on first edge. `period`=4 with `period_valid` on each later edge. `locked`=1 in the cycle of the 4th reported period.
- Locked, then hold `clk_div` at 0 → `fault`=1 and `locked`=0 exactly 9 cycles after the last `edge_strobe`. `fault` holds until `clear`.
- Locked, then stretch one period to 6 → `period`=6 with `period_valid`, `fault`=1 the same cycle.
- In MEASURE, 3 good periods then one period of 2 → `locked` stays 0. Lock follows 4 further good periods.
- `clear` in FAULT in the same cycle as a `rise` → `fault`=0 next cycle and state=IDLE. The next edge starts MEASURE and relock follows 4 good periods.
- Duty 3-high/1-low, period 4 → with the macro, `fault` asserts once locked or `locked` never asserts. Without the macro, `locked`=1. Separately, `rst_n` pulse while locked → all outputs 0 immediately.
